dot_vector_feeder: RTL

Supplies the operand stream for the dot-product compute unit and collects its result. The host loads two 8-element vectors into local register files, then pulses go. The feeder issues a one-cycle START and presents element pairs 0..7 on dataA/dataB in lock-step with the compute unit's internal counter. It then waits for DONE and latches the 16-bit result for the host.

---
 rtl/dot_vector_feeder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dot_vector_feeder.sv
// ---------------------------------------------------------------------------
// dot_vector_feeder
//
// Purpose:
//   Operand sequencer for the dot-product compute unit. The host fills two
//   local register files (vector A and vector B), then requests a run with
//   go. The feeder pulses START for one cycle and then streams element pairs
//   0..N_ELEM-1 on dataA/dataB, one per cycle. This matches the compute
//   unit's internal element counter. It then waits for DONE and latches
//   result_in for the host.
//
// Optional feature (macro FEEDER_TIMEOUT_EN):
//   When the macro is defined, the WAIT state has a watchdog. If DONE is not
//   seen within TMO_CYC cycles, the feeder returns to IDLE and raises the
//   sticky timeout_err output. When the macro is not defined, WAIT waits
//   indefinitely and the module has no timeout_err port.
//
// Ports:
//   CLK          in   system clock, all logic on posedge
//   RST          in   synchronous active-high reset
//   wr_en        in   host write strobe (honoured only in IDLE)
//   wr_sel       in   target vector: 0 = A, 1 = B
//   wr_addr      in   element index
//   wr_data      in   element value
//   go           in   start request (pulse or level)
//   busy         out  high from ARM through WAIT
//   START        out  one-cycle start pulse to the compute unit
//   dataA/dataB  out  element pair to the compute unit (0 outside FEED)
//   DONE         in   completion flag from the compute unit
//   result_in    in   dot product from the compute unit
//   result_out   out  latched dot product
//   result_valid out  sticky; cleared by the next accepted go or by RST
//   done_pulse   out  one-cycle completion strobe
//   timeout_err  out  (FEEDER_TIMEOUT_EN only) sticky watchdog flag
// ---------------------------------------------------------------------------
module dot_vector_feeder #(
    parameter int N_ELEM  = 8,
    parameter int DW      = 8,
    parameter int RW      = 16
`ifdef FEEDER_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 16
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [2:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          go,
    output logic          busy,
    output logic          START,
    output logic [DW-1:0] dataA,
    output logic [DW-1:0] dataB,
    input  logic          DONE,
    input  logic [RW-1:0] result_in,
    output logic [RW-1:0] result_out,
    output logic          result_valid,
    output logic          done_pulse
`ifdef FEEDER_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam int IW = $clog2(N_ELEM);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_FEED = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] resOut_q, resOut_d;
    logic          resValid_q, resValid_d;
    logic          donePulse_q, donePulse_d;

    logic [DW-1:0] memA_q [N_ELEM];
    logic [DW-1:0] memB_q [N_ELEM];

    logic          wrOk;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmoCnt_q, tmoCnt_d;
    logic          tmoErr_q, tmoErr_d;
`endif

    // The host can only write while idle. A write in the same cycle as an
    // accepted go still commits, so the run sees the new element.
    assign wrOk = wr_en && (state_q == S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_ELEM; i++) begin
                memA_q[i] <= '0;
                memB_q[i] <= '0;
            end
        end else if (wrOk) begin
            if (wr_sel) begin
                memB_q[wr_addr] <= wr_data;
            end else begin
                memA_q[wr_addr] <= wr_data;
            end
        end
    end

    // DONE is only considered in WAIT. The compute unit holds DONE from the
    // previous run until it sees START, so DONE must not be trusted earlier.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        resOut_d    = resOut_q;
        resValid_d  = resValid_q;
        donePulse_d = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        tmoCnt_d    = tmoCnt_q;
        tmoErr_d    = tmoErr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_ARM;
                    resValid_d = 1'b0;
                    idx_d      = '0;
`ifdef FEEDER_TIMEOUT_EN
                    tmoErr_d   = 1'b0;
`endif
                end
            end
            S_ARM: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                if (idx_q == IW'(N_ELEM - 1)) begin
                    state_d  = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
                    tmoCnt_d = '0;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (DONE) begin
                    state_d     = S_IDLE;
                    resOut_d    = result_in;
                    resValid_d  = 1'b1;
                    donePulse_d = 1'b1;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (tmoCnt_q == TW'(TMO_CYC - 1)) begin
                    state_d  = S_IDLE;
                    tmoErr_d = 1'b1;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            resOut_q    <= '0;
            resValid_q  <= 1'b0;
            donePulse_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            tmoCnt_q    <= '0;
            tmoErr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            resOut_q    <= resOut_d;
            resValid_q  <= resValid_d;
            donePulse_q <= donePulse_d;
`ifdef FEEDER_TIMEOUT_EN
            tmoCnt_q    <= tmoCnt_d;
            tmoErr_q    <= tmoErr_d;
`endif
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign START        = (state_q == S_ARM);
    assign dataA        = (state_q == S_FEED) ? memA_q[idx_q] : '0;
    assign dataB        = (state_q == S_FEED) ? memB_q[idx_q] : '0;
    assign result_out   = resOut_q;
    assign result_valid = resValid_q;
    assign done_pulse   = donePulse_q;
`ifdef FEEDER_TIMEOUT_EN
    assign timeout_err  = tmoErr_q;
`endif

endmodule
